// File: rtl/byte_stream_formatter_if.sv
// byte_stream_formatter_if
//   Groups the word input handshake, the character output handshake and the
//   busy flag of byte_stream_formatter.
//   slave  : formatter side (consumes words, produces characters)
//   master : environment side (produces words, consumes characters)
//   in_valid/in_ready/in_data/mode   word input, mode 0 = hex, 1 = binary
//   out_valid/out_ready/out_char/out_last   ASCII character output
//   busy                             formatter has work pending
interface byte_stream_formatter_if #(
    parameter int DATA_W = 8
) ();
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              mode;
    logic              out_valid;
    logic              out_ready;
    logic [7:0]        out_char;
    logic              out_last;
    logic              busy;

    modport slave (
        input  in_valid, in_data, mode, out_ready,
        output in_ready, out_valid, out_char, out_last, busy
    );

    modport master (
        output in_valid, in_data, mode, out_ready,
        input  in_ready, out_valid, out_char, out_last, busy
    );
endinterface

// File: rtl/byte_stream_formatter.sv
// byte_stream_formatter
//   Converts DATA_W-bit words into ASCII text, one character per output
//   handshake: lowercase hex (MS nibble first) or binary (MSB first), each
//   word terminated by 0x0A with out_last=1. Words pass through a DEPTH-entry
//   FIFO; words equal to FILTER_VAL are accepted and dropped when FILTER_EN=1.
// Ports
//   clk       clock, rising edge
//   reset_n   asynchronous reset, active low
//   bus       byte_stream_formatter_if.slave (word in / char out / busy)
//   word_cnt  words emitted, saturating         (only with BSF_STATS_EN)
//   drop_cnt  filtered words, saturating        (only with BSF_STATS_EN)
// Configuration macro
//   BSF_STATS_EN  adds the word_cnt / drop_cnt statistics outputs.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | no word in flight, waiting for the FIFO to hold a word
// EMIT  | presenting digit characters of the current word
// EOL   | presenting the terminating newline (out_last=1)
module byte_stream_formatter #(
    parameter int         DATA_W     = 8,
    parameter int         DEPTH      = 4,
    parameter bit         FILTER_EN  = 1'b1,
    parameter logic [7:0] FILTER_VAL = 8'h0A
) (
    input  logic                     clk,
    input  logic                     reset_n,
    byte_stream_formatter_if.slave   bus
`ifdef BSF_STATS_EN
    ,
    output logic [15:0]              word_cnt,
    output logic [15:0]              drop_cnt
`endif
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DATA_W + 1);
    localparam int EW = (DATA_W > 8) ? DATA_W : 8;
    localparam logic [CW-1:0] HEX_LAST = CW'(DATA_W / 4 - 1);
    localparam logic [CW-1:0] BIN_LAST = CW'(DATA_W - 1);

    typedef enum logic [1:0] {IDLE, EMIT, EOL} state_t;

    state_t            state;
    logic [DATA_W:0]   mem [DEPTH];
    logic [AW-1:0]     wr_ptr, rd_ptr;
    logic [AW:0]       count;
    logic              full, accept, filtered, push, pop;
    logic [DATA_W:0]   head;
    logic [DATA_W-1:0] sh, sh_shift;
    logic              cur_bin;
    logic [CW-1:0]     chars_left;
    logic              out_valid_q, out_last_q;
    logic [7:0]        out_char_q;

    // ASCII for the most significant digit of v
    function automatic logic [7:0] digit_char(input logic bin, input logic [DATA_W-1:0] v);
        logic [3:0] nib;
        nib = v[DATA_W-1 -: 4];
        if (bin)
            return v[DATA_W-1] ? 8'h31 : 8'h30;
        else if (nib < 4'd10)
            return 8'h30 + {4'h0, nib};
        else
            return 8'h57 + {4'h0, nib};
    endfunction

    assign full     = (count == (AW+1)'(DEPTH));
    assign filtered = FILTER_EN && (EW'(bus.in_data) == EW'(FILTER_VAL));
    assign accept   = bus.in_valid && !full;
    assign push     = accept && !filtered;
    // Head is consumed when idle, or at the newline handshake so the next word
    // follows without a bubble cycle.
    assign pop      = (count != '0) && ((state == IDLE) || (state == EOL && bus.out_ready));
    assign head     = mem[rd_ptr];
    assign sh_shift = cur_bin ? (sh << 1) : (sh << 4);

    assign bus.in_ready  = !full;
    assign bus.out_valid = out_valid_q;
    assign bus.out_char  = out_char_q;
    assign bus.out_last  = out_last_q;
    assign bus.busy      = (count != '0) || (state != IDLE);

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= {bus.mode, bus.in_data};
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)
                count <= count + 1'b1;
            else if (pop && !push)
                count <= count - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            out_valid_q <= 1'b0;
            out_char_q  <= 8'h00;
            out_last_q  <= 1'b0;
            sh          <= '0;
            cur_bin     <= 1'b0;
            chars_left  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pop) begin
                        state       <= EMIT;
                        out_valid_q <= 1'b1;
                        out_last_q  <= 1'b0;
                        sh          <= head[DATA_W-1:0];
                        cur_bin     <= head[DATA_W];
                        out_char_q  <= digit_char(head[DATA_W], head[DATA_W-1:0]);
                        chars_left  <= head[DATA_W] ? BIN_LAST : HEX_LAST;
                    end
                end
                EMIT: begin
                    if (bus.out_ready) begin
                        if (chars_left == '0) begin
                            state      <= EOL;
                            out_char_q <= 8'h0A;
                            out_last_q <= 1'b1;
                        end else begin
                            sh         <= sh_shift;
                            out_char_q <= digit_char(cur_bin, sh_shift);
                            chars_left <= chars_left - CW'(1);
                        end
                    end
                end
                EOL: begin
                    if (bus.out_ready) begin
                        out_last_q <= 1'b0;
                        if (pop) begin
                            state      <= EMIT;
                            sh         <= head[DATA_W-1:0];
                            cur_bin    <= head[DATA_W];
                            out_char_q <= digit_char(head[DATA_W], head[DATA_W-1:0]);
                            chars_left <= head[DATA_W] ? BIN_LAST : HEX_LAST;
                        end else begin
                            state       <= IDLE;
                            out_valid_q <= 1'b0;
                            out_char_q  <= 8'h00;
                        end
                    end
                end
                default: begin
                    state       <= IDLE;
                    out_valid_q <= 1'b0;
                    out_last_q  <= 1'b0;
                end
            endcase
        end
    end

`ifdef BSF_STATS_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            word_cnt <= '0;
            drop_cnt <= '0;
        end else begin
            if (state == EOL && bus.out_ready && word_cnt != 16'hFFFF)
                word_cnt <= word_cnt + 16'd1;
            if (accept && filtered && drop_cnt != 16'hFFFF)
                drop_cnt <= drop_cnt + 16'd1;
        end
    end
`endif
endmodule

// File: tb/tb_byte_stream_formatter.sv
// Testbench for byte_stream_formatter: directed scenarios followed by random
// words, modes and sink back-pressure. Expected characters are produced from
// text formatting of each accepted word and queued; a monitor pops and
// compares on every output handshake.
module tb_byte_stream_formatter;
    localparam int DATA_W = 8;
    localparam int DEPTH  = 4;

    logic clk;
    logic reset_n;
`ifdef BSF_STATS_EN
    logic [15:0] word_cnt;
    logic [15:0] drop_cnt;
`endif

    byte_stream_formatter_if #(.DATA_W(DATA_W)) bus ();

    byte_stream_formatter #(
        .DATA_W    (DATA_W),
        .DEPTH     (DEPTH),
        .FILTER_EN (1'b1),
        .FILTER_VAL(8'h0A)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
`ifdef BSF_STATS_EN
        ,
        .word_cnt(word_cnt),
        .drop_cnt(drop_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         errors = 0;
    int         checks = 0;
    logic [8:0] exp_q[$];
    int         exp_words = 0;
    int         exp_drops = 0;
    logic       rnd_ready = 1'b0;
    logic       ready_force = 1'b1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: the word's text as a dump routine would print it.
    task automatic model_accept(input logic [DATA_W-1:0] d, input logic m);
        string s;
        if (d == 8'h0A) begin
            exp_drops++;
        end else begin
            s = m ? $sformatf("%08b", d) : $sformatf("%02h", d);
            for (int i = 0; i < s.len(); i++)
                exp_q.push_back({1'b0, s[i]});
            exp_q.push_back({1'b1, 8'h0A});
            exp_words++;
        end
    endtask

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send_word(input logic [DATA_W-1:0] d, input logic m);
        int n;
        n = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.mode     = m;
        while (!bus.in_ready && n < 1000) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 1000) begin
            check("accept_timeout", 64'(1), 64'(0));
        end else begin
            model_accept(d, m);
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || bus.busy) && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        check("drain_done", 64'(n < budget), 64'(1));
    endtask

    // Sink ready driver, the only writer of out_ready.
    initial begin
        bus.out_ready = 1'b1;
        forever begin
            @(posedge clk); #2;
            bus.out_ready = rnd_ready ? ($urandom_range(0, 3) != 0) : ready_force;
        end
    end

    // Monitor: compares each handshake and checks hold during stalls.
    initial begin
        logic       stalled;
        logic [8:0] held;
        logic [8:0] e;
        stalled = 1'b0;
        held    = '0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                stalled = 1'b0;
                continue;
            end
            if (stalled) begin
                check("hold_valid", 64'(bus.out_valid), 64'(1));
                check("hold_char", 64'({bus.out_last, bus.out_char}), 64'(held));
            end
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_char: got %02h with nothing expected at %0t",
                             bus.out_char, $time);
                end else begin
                    e = exp_q.pop_front();
                    check("char", 64'({bus.out_last, bus.out_char}), 64'(e));
                end
                stalled = 1'b0;
            end else if (bus.out_valid) begin
                stalled = 1'b1;
                held    = {bus.out_last, bus.out_char};
            end else begin
                stalled = 1'b0;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;
        reset_n      = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        bus.mode     = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 64'(bus.out_valid), 64'(0));
        check("rst_out_char", 64'(bus.out_char), 64'(0));
        check("rst_out_last", 64'(bus.out_last), 64'(0));
        check("rst_busy", 64'(bus.busy), 64'(0));
        check("rst_in_ready", 64'(bus.in_ready), 64'(1));
        reset_n = 1'b1;
        @(posedge clk); #1;

        // hex word with first-character latency
        send_word(8'h41, 1'b0);
        check("latency_before", 64'(bus.out_valid), 64'(0));
        @(posedge clk); #1;
        check("latency_after", 64'(bus.out_valid), 64'(1));
        wait_drain(100);

        // binary word
        send_word(8'hA5, 1'b1);
        wait_drain(100);

        // filtered word followed by a real one
        send_word(8'h0A, 1'b0);
        send_word(8'hFF, 1'b0);
        wait_drain(100);
`ifdef BSF_STATS_EN
        check("drop_cnt_t3", 64'(drop_cnt), 64'(1));
`endif

        // back-pressure until full: the FSM holds one word besides the FIFO
        ready_force = 1'b0;
        acc = 0;
        for (int k = 0; k < DEPTH + 3; k++) begin
            if (!bus.in_ready) break;
            bus.in_valid = 1'b1;
            bus.in_data  = 8'h20 + 8'(k * 17);
            bus.mode     = k[0];
            model_accept(bus.in_data, bus.mode);
            @(posedge clk); #1;
            acc++;
        end
        bus.in_valid = 1'b0;
        check("full_accepts", 64'(acc), 64'(DEPTH + 1));
        check("full_in_ready", 64'(bus.in_ready), 64'(0));
        check("full_busy", 64'(bus.busy), 64'(1));
        repeat (5) begin @(posedge clk); #1; end
        check("full_still_valid", 64'(bus.out_valid), 64'(1));
        ready_force = 1'b1;
        wait_drain(200);

        // two words back-to-back, no bubble between them
        send_word(8'h12, 1'b0);
        send_word(8'h34, 1'b0);
        for (int k = 0; k < 6; k++) begin
            check("b2b_valid", 64'(bus.out_valid), 64'(1));
            @(posedge clk); #1;
        end
        check("b2b_end", 64'(bus.out_valid), 64'(0));
        wait_drain(100);

        // reset after the first character of a word
        send_word(8'h55, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset_n = 1'b0;
        #1;
        check("midrst_out_valid", 64'(bus.out_valid), 64'(0));
        check("midrst_out_char", 64'(bus.out_char), 64'(0));
        exp_q.delete();
        exp_words = 0;
        exp_drops = 0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        check("postrst_busy", 64'(bus.busy), 64'(0));
        check("postrst_in_ready", 64'(bus.in_ready), 64'(1));
        send_word(8'h7E, 1'b0);
        wait_drain(100);

        // random words, modes and sink stalls
        rnd_ready = 1'b1;
        for (int w = 0; w < 300; w++) begin
            logic [7:0] d;
            d = ($urandom_range(0, 7) == 0) ? 8'h0A : 8'($urandom);
            send_word(d, 1'($urandom_range(0, 1)));
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        end
        rnd_ready = 1'b0;
        ready_force = 1'b1;
        wait_drain(5000);
        check("final_queue_empty", 64'(exp_q.size()), 64'(0));
`ifdef BSF_STATS_EN
        check("word_cnt", 64'(word_cnt), 64'(exp_words));
        check("drop_cnt", 64'(drop_cnt), 64'(exp_drops));
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
